// File: rtl/sim_harness_ctrl_if.sv
// Store-snoop bus between the core's data-memory port and sim_harness_ctrl.
//   st_en   : store strobe
//   st_addr : store address
//   st_data : store data
//   st_be   : store byte enables
// master = core side (drives), slave = harness side (observes).
interface sim_harness_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                  st_en;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [DATA_WIDTH-1:0] st_data;
    logic [BE_WIDTH-1:0]   st_be;

    modport master (output st_en, st_addr, st_data, st_be);
    modport slave  (input  st_en, st_addr, st_data, st_be);
endinterface

// File: rtl/sim_harness_ctrl.sv
// Run-control block for core-level simulation and FPGA bring-up.
// Holds the core in reset for RST_HOLD_CYCLES after arst_n release, counts
// run cycles, enforces a programmable timeout and ends the test when an odd
// value is stored to TOHOST_ADDR (1 = pass, other odd = fail with exit code).
// Optional console byte port is built only when SIM_HARNESS_CONSOLE_EN is
// defined; otherwise con_valid/con_char are tied to 0.
// Ports:
//   clk, arst_n        clock, asynchronous active-low reset
//   timeout_cycles     run-cycle limit (0 = no timeout), sampled every cycle
//   st                 store-snoop bus (slave modport)
//   core_rst_n         reset to the core, released on entry to RUN
//   running            high while in RUN
//   done/pass/fail/timed_out  sticky end-of-test flags
//   exit_code          tohost value >> 1
//   cycle_count        cycles spent in RUN, saturating
//   con_valid/con_char console byte strobe and byte
module sim_harness_ctrl #(
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR     = ADDR_WIDTH'(32'h0000_0FF0),
    parameter logic [ADDR_WIDTH-1:0] CONSOLE_ADDR    = ADDR_WIDTH'(32'h0000_0FF4),
    parameter int unsigned           CNT_WIDTH       = 32,
    parameter int unsigned           RST_HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [CNT_WIDTH-1:0]  timeout_cycles,
    sim_harness_ctrl_if.slave     st,
    output logic                  core_rst_n,
    output logic                  running,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timed_out,
    output logic [DATA_WIDTH-2:0] exit_code,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic                  con_valid,
    output logic [7:0]            con_char
);

    localparam int unsigned HOLD_W = $clog2(RST_HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_RUN  = 2'd1,
        S_END  = 2'd2
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              tohost_end;
    logic              timeout_hit;

    // Odd full-word store to tohost ends the test; even or partial stores do not.
    always_comb begin
        tohost_end  = 1'b0;
        timeout_hit = 1'b0;
        tohost_end  = st.st_en && (st.st_addr == TOHOST_ADDR) && (&st.st_be)
                      && st.st_data[0];
        // Equality (not >=) so lowering the limit below the count never fires.
        timeout_hit = (timeout_cycles != '0)
                      && (cycle_count == timeout_cycles - CNT_WIDTH'(1));
    end

    // HOLD -> RUN -> END sequencer with registered outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= S_HOLD;
            hold_cnt    <= HOLD_W'(RST_HOLD_CYCLES);
            core_rst_n  <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timed_out   <= 1'b0;
            exit_code   <= '0;
            cycle_count <= '0;
        end else begin
            case (state)
                S_HOLD: begin
                    // Release on the RST_HOLD_CYCLES-th edge after arst_n rises.
                    if (hold_cnt <= HOLD_W'(1)) begin
                        state      <= S_RUN;
                        hold_cnt   <= '0;
                        core_rst_n <= 1'b1;
                        running    <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + CNT_WIDTH'(1);
                    end
                    // tohost result has priority over a same-cycle timeout.
                    if (tohost_end) begin
                        state     <= S_END;
                        running   <= 1'b0;
                        done      <= 1'b1;
                        pass      <= (st.st_data == DATA_WIDTH'(1));
                        fail      <= (st.st_data != DATA_WIDTH'(1));
                        exit_code <= st.st_data[DATA_WIDTH-1:1];
                    end else if (timeout_hit) begin
                        state     <= S_END;
                        running   <= 1'b0;
                        done      <= 1'b1;
                        timed_out <= 1'b1;
                    end
                end
                S_END: begin
                    state <= S_END;
                end
                default: begin
                    state <= S_HOLD;
                end
            endcase
        end
    end

`ifdef SIM_HARNESS_CONSOLE_EN
    logic con_hit;

    always_comb begin
        con_hit = 1'b0;
        con_hit = (state == S_RUN) && st.st_en && (st.st_addr == CONSOLE_ADDR)
                  && st.st_be[0];
    end

    // One-cycle strobe per console store; byte held until the next one.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            con_valid <= 1'b0;
            con_char  <= '0;
        end else begin
            con_valid <= con_hit;
            if (con_hit) begin
                con_char <= st.st_data[7:0];
            end
        end
    end
`else
    assign con_valid = 1'b0;
    assign con_char  = '0;
`endif

endmodule

// File: tb/tb_sim_harness_ctrl.sv
// Randomized self-checking bench for sim_harness_ctrl. The reference model
// works in terms of the RUN edge index k: the test ends on the first edge
// carrying an odd full-word tohost store, or else on the edge where
// k == timeout_cycles; cycle_count is min(k, 2^CNT_WIDTH-1).
module tb_sim_harness_ctrl;

    localparam int unsigned DW      = 32;
    localparam int unsigned AW      = 32;
    localparam int unsigned CW      = 8;
    localparam int unsigned R       = 4;
    localparam logic [AW-1:0] TOHOST  = 32'h0000_0FF0;
    localparam logic [AW-1:0] CONSOLE = 32'h0000_0FF4;
    localparam int          CNT_MAX = (1 << CW) - 1;
`ifdef SIM_HARNESS_CONSOLE_EN
    localparam bit CON_EN = 1'b1;
`else
    localparam bit CON_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          arst_n;
    logic [CW-1:0] timeout_cycles;
    logic          core_rst_n, running, done, pass, fail, timed_out;
    logic [DW-2:0] exit_code;
    logic [CW-1:0] cycle_count;
    logic          con_valid;
    logic [7:0]    con_char;

    sim_harness_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) st_bus ();

    sim_harness_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TOHOST_ADDR(TOHOST),
        .CONSOLE_ADDR(CONSOLE), .CNT_WIDTH(CW), .RST_HOLD_CYCLES(R)
    ) dut (
        .clk(clk), .arst_n(arst_n), .timeout_cycles(timeout_cycles),
        .st(st_bus.slave),
        .core_rst_n(core_rst_n), .running(running), .done(done),
        .pass(pass), .fail(fail), .timed_out(timed_out),
        .exit_code(exit_code), .cycle_count(cycle_count),
        .con_valid(con_valid), .con_char(con_char)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    string cur_sc   = "init";

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s/%s: got 0x%0h expected 0x%0h", cur_sc, tag, got, exp);
        end
    endtask

    // Drive one store (or idle) onto the snoop bus.
    task automatic drive_st(input logic en, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic [3:0] be);
        st_bus.st_en   = en;
        st_bus.st_addr = addr;
        st_bus.st_data = data;
        st_bus.st_be   = be;
    endtask

    // Async reset between edges; every output must clear at once.
    task automatic apply_reset(input string name);
        cur_sc = name;
        @(posedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        chk("rst_core_rst_n", 64'(core_rst_n), 64'(0));
        chk("rst_running",    64'(running),    64'(0));
        chk("rst_done",       64'(done),       64'(0));
        chk("rst_pass",       64'(pass),       64'(0));
        chk("rst_fail",       64'(fail),       64'(0));
        chk("rst_timed_out",  64'(timed_out),  64'(0));
        chk("rst_exit_code",  64'(exit_code),  64'(0));
        chk("rst_cycle_cnt",  64'(cycle_count), 64'(0));
        chk("rst_con_valid",  64'(con_valid),  64'(0));
        chk("rst_con_char",   64'(con_char),   64'(0));
    endtask

    // Random store that can never end the test unless allow_end is set.
    task automatic drive_noise(input bit allow_end);
        int unsigned kind;
        logic [DW-1:0] d;
        kind = $urandom_range(0, allow_end ? 4 : 3);
        d = DW'($urandom);
        case (kind)
            0: drive_st(1'b1, AW'(32'h0000_1000 + ($urandom_range(0, 255) << 2)), d,
                        4'($urandom_range(0, 15)));
            1: drive_st(1'b1, TOHOST, d & ~DW'(1), 4'hF);
            2: drive_st(1'b1, TOHOST, d | DW'(1), 4'($urandom_range(0, 14)));
            3: drive_st(1'b1, CONSOLE, d, 4'($urandom_range(0, 15)));
            default: drive_st(1'b1, TOHOST, d | DW'(1), 4'hF);
        endcase
    endtask

    task automatic run_sc(input string name, input logic [CW-1:0] t_init,
                          input int chg_edge, input logic [CW-1:0] t_new,
                          input int s_edge, input logic [DW-1:0] s_val,
                          input bit ign_seq, input bit con_seq, input bit noise,
                          input int max_len);
        bit            ended;
        int            end_k;
        logic [CW-1:0] tk;
        logic          e_done, e_pass, e_fail, e_to, e_con_valid;
        logic [DW-2:0] e_exit;
        int            e_cnt;
        logic [7:0]    e_con_char;
        bit            ends_now, con_now;

        apply_reset(name);
        timeout_cycles = t_init;
        drive_st(1'b1, TOHOST, DW'(1), 4'hF);
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;

        // Hold phase: stores here must be ignored.
        for (int e = 1; e <= int'(R); e++) begin
            if (e > 1) @(negedge clk);
            if (e % 2 == 1) drive_st(1'b1, TOHOST, DW'(1), 4'hF);
            else            drive_st(1'b1, CONSOLE, DW'(32'h21), 4'h1);
            @(posedge clk);
            #1;
            chk("hold_core_rst_n", 64'(core_rst_n), 64'(e == int'(R)));
            chk("hold_running",    64'(running),    64'(e == int'(R)));
            chk("hold_cycle_cnt",  64'(cycle_count), 64'(0));
            chk("hold_done",       64'(done),       64'(0));
            chk("hold_con_valid",  64'(con_valid),  64'(0));
        end

        ended = 1'b0; end_k = 0;
        e_done = 0; e_pass = 0; e_fail = 0; e_to = 0; e_exit = '0; e_cnt = 0;
        e_con_char = '0;
        for (int k = 1; k <= max_len; k++) begin
            @(negedge clk);
            tk = (chg_edge > 0 && k >= chg_edge) ? t_new : t_init;
            timeout_cycles = tk;
            drive_st(1'b0, '0, '0, 4'h0);
            if (k == s_edge)                      drive_st(1'b1, TOHOST, s_val, 4'hF);
            else if (ign_seq && k == s_edge - 2)  drive_st(1'b1, TOHOST, DW'(4), 4'hF);
            else if (ign_seq && k == s_edge - 1)  drive_st(1'b1, TOHOST, DW'(7), 4'h3);
            else if (con_seq && k == 5)           drive_st(1'b1, CONSOLE, DW'(32'h48), 4'h1);
            else if (con_seq && k == 6)           drive_st(1'b1, CONSOLE, DW'(32'h69), 4'hF);
            else if (noise && $urandom_range(0, 1) == 1) drive_noise(ended);

            // Reference model for this edge.
            con_now  = st_bus.st_en && st_bus.st_addr == CONSOLE && st_bus.st_be[0] && !ended;
            e_con_valid = CON_EN && con_now;
            if (CON_EN && con_now) e_con_char = st_bus.st_data[7:0];
            if (!ended) begin
                e_cnt = (k > CNT_MAX) ? CNT_MAX : k;
                ends_now = st_bus.st_en && st_bus.st_addr == TOHOST
                           && st_bus.st_be == 4'hF && st_bus.st_data[0];
                if (ends_now) begin
                    ended = 1'b1; end_k = k; e_done = 1;
                    e_pass = (st_bus.st_data == DW'(1));
                    e_fail = !e_pass;
                    e_exit = st_bus.st_data[DW-1:1];
                end else if (tk != '0 && k == int'(tk)) begin
                    ended = 1'b1; end_k = k; e_done = 1; e_to = 1;
                end
            end

            @(posedge clk);
            #1;
            chk("core_rst_n",  64'(core_rst_n),  64'(1));
            chk("running",     64'(running),     64'(!ended));
            chk("done",        64'(done),        64'(e_done));
            chk("pass",        64'(pass),        64'(e_pass));
            chk("fail",        64'(fail),        64'(e_fail));
            chk("timed_out",   64'(timed_out),   64'(e_to));
            chk("exit_code",   64'(exit_code),   64'(e_exit));
            chk("cycle_count", 64'(cycle_count), 64'(e_cnt));
            chk("con_valid",   64'(con_valid),   64'(e_con_valid));
            chk("con_char",    64'(con_char),    64'(e_con_char));
            if (ended && k >= end_k + 5) break;
        end
        drive_st(1'b0, '0, '0, 4'h0);
    endtask

    initial begin
        logic [CW-1:0] rt, rtn;
        int            rs, rc;
        logic [DW-1:0] rv;

        arst_n = 1'b0;
        timeout_cycles = '0;
        drive_st(1'b0, '0, '0, 4'h0);
        repeat (2) @(posedge clk);

        run_sc("pass",       CW'(0),   0,   CW'(0),  101, DW'(1), 1'b0, 1'b0, 1'b1, 120);
        run_sc("fail",       CW'(0),   0,   CW'(0),  30,  DW'(7), 1'b1, 1'b0, 1'b0, 40);
        run_sc("timeout",    CW'(50),  0,   CW'(0),  0,   DW'(0), 1'b0, 1'b0, 1'b1, 70);
        run_sc("no_timeout", CW'(0),   0,   CW'(0),  0,   DW'(0), 1'b0, 1'b0, 1'b1, 10000);
        run_sc("collide",    CW'(40),  0,   CW'(0),  40,  DW'(1), 1'b0, 1'b0, 1'b1, 60);
        run_sc("lower",      CW'(200), 100, CW'(30), 150, DW'(5), 1'b0, 1'b0, 1'b1, 170);
        run_sc("raise",      CW'(20),  10,  CW'(60), 0,   DW'(0), 1'b0, 1'b0, 1'b1, 80);
        run_sc("console",    CW'(0),   0,   CW'(0),  20,  DW'(1), 1'b0, 1'b1, 1'b0, 30);

        for (int i = 0; i < 20; i++) begin
            rt  = ($urandom_range(0, 3) == 0) ? CW'(0) : CW'($urandom_range(1, 255));
            rtn = CW'($urandom_range(0, 255));
            rc  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 200)) : 0;
            rs  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 300));
            rv  = ($urandom_range(0, 1) == 1) ? DW'(1) : (DW'($urandom) | DW'(1));
            run_sc($sformatf("rand%0d", i), rt, rc, rtn, rs, rv, 1'b0, 1'b0, 1'b1, 320);
        end

        apply_reset("final");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sim_harness_ctrl.md
# sim_harness_ctrl

- Synthesizable run-control block for core-level simulation and FPGA bring-up.
- Sequences the core's reset, counts run cycles, and enforces a run-time-programmable timeout.
- Detects end-of-test by snooping data-memory stores to a `tohost` address and reports pass, fail or timeout with an exit code.
- Sits beside `core_top`, replacing free-running testbench timers with a deterministic, parametrised controller.

## Interface

Parameters:
- `DATA_WIDTH`, 32: store data width; multiple of 8.
- `ADDR_WIDTH`, 32: store address width.
- `TOHOST_ADDR`, 32'h0000_0FF0: end-of-test mailbox address.
- `CONSOLE_ADDR`, 32'h0000_0FF4: console byte address; used only with `SIM_HARNESS_CONSOLE_EN`.
- `CNT_WIDTH`, 32: width of the cycle counter and the timeout value.
- `RST_HOLD_CYCLES`, 4: cycles `core_rst_n` stays low after `arst_n` deasserts; minimum 1.

Ports:
- `clk`  in  1  system clock.
- `arst_n`  in  1  asynchronous, active-low reset.
- `timeout_cycles`  in  CNT_WIDTH  run-cycle limit; 0 disables the timeout; sampled every cycle.
- `st_en`  in  1  core data-memory store strobe.
- `st_addr`  in  ADDR_WIDTH  store address.
- `st_data`  in  DATA_WIDTH  store data.
- `st_be`  in  DATA_WIDTH/8  store byte enables.
- `core_rst_n`  out  1  synchronous-release reset to the core.
- `running`  out  1  high while in RUN.
- `done`  out  1  sticky; test finished by any cause.
- `pass`  out  1  sticky; tohost value == 1.
- `fail`  out  1  sticky; tohost odd value != 1.
- `timed_out`  out  1  sticky; timeout expired.
- `exit_code`  out  DATA_WIDTH-1  tohost value >> 1.
- `cycle_count`  out  CNT_WIDTH  cycles spent in RUN; saturates at all-ones.
- `con_valid`  out  1  one-cycle console byte strobe.
- `con_char`  out  8  console byte.

## Operation

State machine: HOLD -> RUN -> END.
- HOLD:
  - Entered asynchronously on `arst_n` low.
  - Down-counter loads `RST_HOLD_CYCLES`.
  - `core_rst_n` stays 0.
  - Moves to RUN when the counter reaches 0 after `arst_n` release.
- RUN:
  - `core_rst_n` = 1 and `running` = 1.
  - `cycle_count` increments every cycle.
  - Stores are snooped.
- END:
  - Absorbing state; all flags frozen.
  - `core_rst_n` stays 1, so the core keeps running, but stores are ignored.
  - Leaves only through `arst_n`.

tohost decode, active only in RUN: a hit requires `st_en`, `st_addr == TOHOST_ADDR` and all `st_be` bits set.
- Even value: ignored; stay in RUN.
- Value == 1: `pass` set.
- Other odd value: `fail` set, `exit_code` = `st_data >> 1`.
- Any odd value: `done` set, go to END.
- Partial-byte-enable writes to `TOHOST_ADDR` are ignored.

Timeout:
- Fires when `timeout_cycles != 0` and `cycle_count == timeout_cycles - 1` in RUN.
- Sets `timed_out` and `done`; goes to END.
- Simultaneous tohost hit and timeout: the tohost result wins and `timed_out` stays 0.
- `timeout_cycles` changing mid-run takes effect immediately.
- Lowering it below the current count never fires; the run continues until tohost arrives.

Counting:
- `cycle_count` saturates at 2^CNT_WIDTH-1.
- It freezes in END.

## Timing

- Reset values: `core_rst_n`, `running`, `done`, `pass`, `fail`, `timed_out`, `con_valid` = 0; `exit_code`, `cycle_count`, `con_char` = 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `core_rst_n` rises on the `RST_HOLD_CYCLES`-th rising `clk` edge after `arst_n` deasserts.
- `running` rises on the same edge as `core_rst_n`.
- A tohost hit sampled at edge N makes `done`/`pass`/`fail`/`exit_code` visible after edge N; `running` falls on that same edge.
- `cycle_count` reads 1 after the first RUN edge.
- `arst_n` asserted mid-run clears every output immediately, asynchronously, and restarts HOLD.

## Configuration

- `SIM_HARNESS_CONSOLE_EN` defined:
  - A store in RUN with `st_en`, `st_addr == CONSOLE_ADDR` and `st_be[0]` set pulses `con_valid` for one cycle on the next edge.
  - `con_char` is registered from `st_data[7:0]` and held until the next console store.
  - Back-to-back stores give back-to-back pulses.
  - Console stores in HOLD or END are ignored.
- `SIM_HARNESS_CONSOLE_EN` undefined:
  - `con_valid` and `con_char` are tied to 0.
  - No console decode logic is built.
  - `CONSOLE_ADDR` is unused.

## Test plan

- Reset hold: `RST_HOLD_CYCLES`=4, release `arst_n` -> `core_rst_n`=0 for 4 edges, rises on the 4th; `cycle_count`=1 one edge later.
- Pass: after 100 RUN cycles, store 32'h1 to `TOHOST_ADDR` with `st_be`=4'hF -> `done`=`pass`=1, `fail`=0, `exit_code`=0, `cycle_count` frozen at 101.
- Fail plus ignored writes: store 32'h4 (even), then 32'h7 with `st_be`=4'h3, then 32'h7 with `st_be`=4'hF:
  - first two stores are ignored;
  - third store gives `fail`=1, `exit_code`=3.
- Timeout: `timeout_cycles`=50, no stores -> `timed_out`=`done`=1 with `cycle_count`=50; `timeout_cycles`=0 -> no timeout after 10000 cycles.
- Collision and reset: tohost 32'h1 on the exact timeout cycle -> `pass`=1, `timed_out`=0; then assert `arst_n` mid-END -> all outputs 0 at once, HOLD restarts.
- Console (macro on): stores 8'h48, 8'h69 on consecutive cycles to `CONSOLE_ADDR` -> two consecutive `con_valid` pulses with `con_char` 8'h48 then 8'h69; macro off -> `con_valid` never rises.
